// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer: byte-wide Ethernet receive deframer.
// It hunts the GMII-style byte stream for preamble + SFD and strips both.
// Frame bytes pass through a short delay buffer, and the FCS is checked
// with a running CRC32 register.
// Optional feature macro: ETH_RX_FCS_STRIP_EN.
//   Defined:   5-byte buffer, so the 4 FCS bytes are withheld.
//   Undefined: 1-byte buffer, so every byte including the FCS is emitted.
module eth_rx_deframer #(
  parameter int PREAMBLE_MIN = 7,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dv,
  input  logic       rx_er,
  input  logic [7:0] rx_data,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_eof,
  output logic       m_crc_ok,
  output logic       m_err
);

`ifdef ETH_RX_FCS_STRIP_EN
  localparam int D = 5;
`else
  localparam int D = 1;
`endif

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [3:0]  PRE_MIN     = 4'(PREAMBLE_MIN);
  localparam logic [10:0] LEN_MIN     = 11'(MIN_FRAME);
  localparam logic [10:0] LEN_MAX     = 11'(MAX_FRAME);
  localparam logic [2:0]  BUF_FULL    = 3'(D);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [3:0]          r_preCnt;
  logic [31:0]         r_crc;
  logic [10:0]         r_len;
  logic [D-1:0][7:0]   r_buf;
  logic [2:0]          r_bufCnt;
  logic                r_sticky;
  logic                r_sofPend;
  logic                w_sfdOk;
  logic [31:0]         w_crcNext;

  // Reflected CRC32 update for one byte, LSB first, with no output inversion.
  function automatic logic [31:0] crcNext(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign w_crcNext = crcNext(r_crc, rx_data);
  assign w_sfdOk   = (r_state == S_PRE) && rx_dv && !rx_er &&
                     (rx_data == 8'hD5) && (r_preCnt >= PRE_MIN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode. A receive error during preamble abandons the frame.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_dv) w_stateNext = (rx_data == 8'h55) ? S_PRE : S_DROP;
      end
      S_PRE: begin
        if (!rx_dv)                  w_stateNext = S_IDLE;
        else if (rx_er)              w_stateNext = S_DROP;
        else if (rx_data == 8'h55)   w_stateNext = S_PRE;
        else if (w_sfdOk)            w_stateNext = S_DATA;
        else                         w_stateNext = S_DROP;
      end
      S_DATA: begin
        if (!rx_dv) w_stateNext = S_IDLE;
      end
      S_DROP: begin
        if (!rx_dv) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Preamble counting, CRC/length tracking, delay buffer and registered beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_preCnt  <= '0;
      r_crc     <= '1;
      r_len     <= '0;
      r_buf     <= '0;
      r_bufCnt  <= '0;
      r_sticky  <= 1'b0;
      r_sofPend <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= 8'h00;
      m_sof     <= 1'b0;
      m_eof     <= 1'b0;
      m_crc_ok  <= 1'b0;
      m_err     <= 1'b0;
    end else begin
      m_valid  <= 1'b0;
      m_data   <= 8'h00;
      m_sof    <= 1'b0;
      m_eof    <= 1'b0;
      m_crc_ok <= 1'b0;
      m_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_preCnt <= 4'd1;
        end
        S_PRE: begin
          if (rx_dv && (rx_data == 8'h55) && (r_preCnt != 4'd15)) begin
            r_preCnt <= r_preCnt + 4'd1;
          end
          if (w_sfdOk) begin
            r_crc     <= '1;
            r_len     <= '0;
            r_bufCnt  <= '0;
            r_sticky  <= 1'b0;
            r_sofPend <= 1'b1;
          end
        end
        S_DATA: begin
          if (rx_dv) begin
            if (rx_er) r_sticky <= 1'b1;
            if (r_len < LEN_MAX) begin
              r_crc <= w_crcNext;
              r_len <= r_len + 11'd1;
              if (r_bufCnt == BUF_FULL) begin
                m_valid   <= 1'b1;
                m_data    <= r_buf[0];
                m_sof     <= r_sofPend;
                r_sofPend <= 1'b0;
                for (int i = 0; i < D - 1; i++) begin
                  r_buf[i] <= r_buf[i+1];
                end
                r_buf[D-1] <= rx_data;
              end else begin
                for (int i = 0; i < D; i++) begin
                  if (r_bufCnt == 3'(i)) r_buf[i] <= rx_data;
                end
                r_bufCnt <= r_bufCnt + 3'd1;
              end
            end else begin
              r_sticky <= 1'b1;
            end
          end else begin
            m_valid  <= 1'b1;
            m_eof    <= 1'b1;
            m_crc_ok <= (r_crc == CRC_RESIDUE);
            if (r_bufCnt == BUF_FULL) begin
              m_data <= r_buf[0];
              m_sof  <= r_sofPend;
              m_err  <= r_sticky || (r_len < LEN_MIN);
            end else begin
              m_data <= 8'h00;
              m_sof  <= 1'b1;
              m_err  <= 1'b1;
            end
            r_bufCnt  <= '0;
            r_sofPend <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Testbench for eth_rx_deframer. It runs the default build and the
// ETH_RX_FCS_STRIP_EN build, and selects the buffer depth D to match.
`timescale 1ns/1ps
module tb_eth_rx_deframer;

`ifdef ETH_RX_FCS_STRIP_EN
  localparam int D = 5;
`else
  localparam int D = 1;
`endif
  localparam int PREAMBLE_MIN = 7;
  localparam int MIN_FRAME    = 64;
  localparam int MAX_FRAME    = 1518;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] rx_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eof;
  logic       m_crc_ok;
  logic       m_err;

  eth_rx_deframer #(
    .PREAMBLE_MIN(PREAMBLE_MIN),
    .MIN_FRAME(MIN_FRAME),
    .MAX_FRAME(MAX_FRAME)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_dv(rx_dv),
    .rx_er(rx_er),
    .rx_data(rx_data),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_sof(m_sof),
    .m_eof(m_eof),
    .m_crc_ok(m_crc_ok),
    .m_err(m_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         sof;
    bit         eof;
    bit         crcOk;
    bit         err;
    int         cyc;
  } beat_t;

  typedef struct {
    int         preLen;
    logic [7:0] sfd;
    int         payLen;
    bit         addFcs;
    int         corruptIdx;
    int         erIdx;
    int         expBeats;
    bit         chkCrc;
    bit         expCrcOk;
    bit         expErr;
  } vec_t;

  beat_t       gotQ[$];
  beat_t       expQ[$];
  logic [7:0]  txData[$];
  bit          txEr[$];
  int          txCyc[$];
  int          lowCyc;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] crcTable [256];
  vec_t        tbl [11];

  // Free-running cycle count, used to time-stamp driven bytes and observed beats.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output beat away from the active edge.
  always @(negedge clk) begin
    beat_t b;
    if (m_valid) begin
      b.data  = m_data;
      b.sof   = m_sof;
      b.eof   = m_eof;
      b.crcOk = m_crc_ok;
      b.err   = m_err;
      b.cyc   = cyc;
      gotQ.push_back(b);
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Table-driven CRC32, reflected polynomial 0xEDB88320.
  task automatic initCrcTable();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crcTable[n] = c;
    end
  endtask

  function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
    return (c >> 8) ^ crcTable[c[7:0] ^ b];
  endfunction

  // Build a preamble + SFD + body stream. The FCS covers the uncorrupted body.
  task automatic buildFrame(input int preLen, input logic [7:0] sfd, input int payLen,
                            input bit addFcs, input int corruptIdx, input int erIdx, input bit rnd);
    logic [7:0]  body[$];
    logic [31:0] c;
    txData.delete();
    txEr.delete();
    for (int i = 0; i < payLen; i++) body.push_back(rnd ? 8'($urandom) : 8'(i));
    if (addFcs) begin
      c = 32'hFFFFFFFF;
      foreach (body[i]) c = crcStep(c, body[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
    end
    if (corruptIdx >= 0 && corruptIdx < body.size()) body[corruptIdx] = body[corruptIdx] ^ 8'h01;
    for (int i = 0; i < preLen; i++) txData.push_back(8'h55);
    txData.push_back(sfd);
    foreach (body[i]) txData.push_back(body[i]);
    for (int i = 0; i < txData.size(); i++) txEr.push_back(i == erIdx);
  endtask

  // Drive the stream, then hold rx_dv low for 'idle' cycles.
  task automatic sendStream(input int idle);
    txCyc.delete();
    foreach (txData[i]) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_data = txData[i];
      rx_er   = txEr[i];
      txCyc.push_back(cyc);
    end
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    rx_data = 8'h00;
    lowCyc  = cyc;
    repeat (idle - 1) @(negedge clk);
  endtask

  // Reference model: parse the stream that was just sent and append the expected beats.
  task automatic modelStream();
    int          n;
    int          k;
    int          start;
    int          rawLen;
    int          acc;
    bit          drop;
    bit          erSeen;
    bit          crcOk;
    bit          err;
    logic [31:0] c;
    beat_t       b;
    n = txData.size();
    k = 0;
    drop = 1'b0;
    while (k < n && txData[k] == 8'h55) k++;
    if (k >= n || txData[k] != 8'hD5 || k < PREAMBLE_MIN) drop = 1'b1;
    for (int j = 1; j <= k && j < n; j++) if (txEr[j]) drop = 1'b1;
    if (drop) return;
    start  = k + 1;
    rawLen = n - start;
    acc    = (rawLen > MAX_FRAME) ? MAX_FRAME : rawLen;
    c      = 32'hFFFFFFFF;
    erSeen = 1'b0;
    for (int i = 0; i < rawLen; i++) begin
      if (txEr[start+i]) erSeen = 1'b1;
      if (i < acc) c = crcStep(c, txData[start+i]);
    end
    crcOk = (c == 32'hDEBB20E3);
    err   = erSeen || (acc < MIN_FRAME) || (rawLen > MAX_FRAME);
    if (acc >= D) begin
      for (int i = 0; i < acc - D; i++) begin
        b.data = txData[start+i]; b.sof = (i == 0); b.eof = 1'b0;
        b.crcOk = 1'b0; b.err = 1'b0; b.cyc = txCyc[start+i+D] + 1;
        expQ.push_back(b);
      end
      b.data = txData[start+acc-D]; b.sof = (acc == D); b.eof = 1'b1;
      b.crcOk = crcOk; b.err = err; b.cyc = lowCyc + 1;
    end else begin
      b.data = 8'h00; b.sof = 1'b1; b.eof = 1'b1;
      b.crcOk = crcOk; b.err = 1'b1; b.cyc = lowCyc + 1;
    end
    expQ.push_back(b);
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  // Compare every captured beat (content and cycle) with the model, then clear both queues.
  task automatic checkOutput(input string tag);
    int n;
    int shown;
    shown = 0;
    checks++;
    if (gotQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL %s beat count: got %0d expected %0d", tag, gotQ.size(), expQ.size());
    end
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gotQ[i].data !== expQ[i].data || gotQ[i].sof != expQ[i].sof ||
          gotQ[i].eof != expQ[i].eof || gotQ[i].crcOk != expQ[i].crcOk ||
          gotQ[i].err != expQ[i].err || gotQ[i].cyc != expQ[i].cyc) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("[TB] FAIL %s beat %0d: got data=%02h sof=%0b eof=%0b crc_ok=%0b err=%0b cyc=%0d expected data=%02h sof=%0b eof=%0b crc_ok=%0b err=%0b cyc=%0d",
                   tag, i, gotQ[i].data, gotQ[i].sof, gotQ[i].eof, gotQ[i].crcOk, gotQ[i].err, gotQ[i].cyc,
                   expQ[i].data, expQ[i].sof, expQ[i].eof, expQ[i].crcOk, expQ[i].err, expQ[i].cyc);
        end
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  // Run one table vector and check the beat count and eof status against fixed values, then against the model.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    buildFrame(v.preLen, v.sfd, v.payLen, v.addFcs, v.corruptIdx, v.erIdx, 1'b0);
    sendStream(3);
    modelStream();
    repeat (3) @(negedge clk);
    checks++;
    if (gotQ.size() != v.expBeats) begin
      errors++;
      $display("[TB] FAIL %s table beat count: got %0d expected %0d", tag, gotQ.size(), v.expBeats);
    end
    if (v.expBeats > 0 && gotQ.size() > 0) begin
      checkBit({tag, " eof"}, gotQ[$].eof, 1'b1);
      checkBit({tag, " err"}, gotQ[$].err, v.expErr);
      if (v.chkCrc) checkBit({tag, " crc_ok"}, gotQ[$].crcOk, v.expCrcOk);
    end
    checkOutput(tag);
  endtask

  // Main sequence: reset, table vectors, reset mid-frame, back-to-back frames, random frames.
  initial begin
    initCrcTable();
    tbl[0]  = '{7,  8'hD5, 60,   1'b1, -1, -1, 65 - D,            1'b1, 1'b1, 1'b0};
    tbl[1]  = '{7,  8'hD5, 60,   1'b1, 10, -1, 65 - D,            1'b1, 1'b0, 1'b0};
    tbl[2]  = '{7,  8'h54, 60,   1'b1, -1, -1, 0,                 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{6,  8'hD5, 60,   1'b1, -1, -1, 0,                 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{7,  8'hD5, 3,    1'b0, -1, -1, (D > 3) ? 1 : 4 - D, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{7,  8'hD5, 36,   1'b1, -1, -1, 41 - D,            1'b1, 1'b1, 1'b1};
    tbl[6]  = '{7,  8'hD5, 60,   1'b1, -1, 28, 65 - D,            1'b1, 1'b1, 1'b1};
    tbl[7]  = '{7,  8'hD5, 1600, 1'b0, -1, -1, MAX_FRAME + 1 - D, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{7,  8'hD5, 1514, 1'b1, -1, -1, MAX_FRAME + 1 - D, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{7,  8'hD5, 59,   1'b1, -1, -1, 64 - D,            1'b1, 1'b1, 1'b1};
    tbl[10] = '{20, 8'hD5, 60,   1'b1, -1, -1, 65 - D,            1'b1, 1'b1, 1'b0};

    rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checkBit("reset m_valid", m_valid, 1'b0);
    checkBit("reset m_sof", m_sof, 1'b0);
    checkBit("reset m_eof", m_eof, 1'b0);
    checkBit("reset m_crc_ok", m_crc_ok, 1'b0);
    checkBit("reset m_err", m_err, 1'b0);
    checkBit("reset m_data", (m_data == 8'h00), 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] table vectors, D=%0d", D);
    for (int i = 0; i < 11; i++) applyStimulus(i, tbl[i]);

    $display("[TB] reset in the middle of a frame");
    buildFrame(7, 8'hD5, 60, 1'b1, -1, -1, 1'b0);
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      rx_dv = 1'b1; rx_data = txData[i]; rx_er = 1'b0;
    end
    @(negedge clk);
    rx_data = txData[38];
    rst = 1'b1;
    #1;
    checkBit("midreset m_valid", m_valid, 1'b0);
    checkBit("midreset m_sof", m_sof, 1'b0);
    checkBit("midreset m_eof", m_eof, 1'b0);
    checkBit("midreset m_data", (m_data == 8'h00), 1'b1);
    @(negedge clk);
    rst = 1'b0; rx_dv = 1'b0; rx_data = 8'h00;
    gotQ.delete();
    expQ.delete();
    repeat (8) @(negedge clk);
    checkOutput("midreset no eof");
    applyStimulus(100, tbl[0]);

    $display("[TB] back-to-back frames with one idle cycle");
    buildFrame(7, 8'h54, 60, 1'b1, -1, -1, 1'b0);
    sendStream(1);
    modelStream();
    buildFrame(7, 8'hD5, 60, 1'b1, -1, -1, 1'b0);
    sendStream(1);
    modelStream();
    buildFrame(7, 8'hD5, 70, 1'b1, -1, -1, 1'b1);
    sendStream(1);
    modelStream();
    repeat (3) @(negedge clk);
    checkOutput("back2back");

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      int pl;
      int pay;
      pl  = $urandom_range(6, 10);
      pay = $urandom_range(0, 90);
      buildFrame(pl, ($urandom_range(0, 9) == 0) ? 8'h5D : 8'hD5, pay,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, pay + 3)) : -1,
                 ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, pl + pay + 5)) : -1,
                 1'b1);
      sendStream($urandom_range(1, 3));
      modelStream();
      if (f % 4 == 3) begin
        repeat (3) @(negedge clk);
        checkOutput($sformatf("random%0d", f));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_deframer.md
# eth_rx_deframer

Byte-wide Ethernet receive deframer sitting directly upstream of the byte-wise CRC32 stage. It hunts a GMII-style byte stream for preamble plus SFD and strips both. It forwards frame bytes (destination MAC through payload) with start/end markers and checks the FCS with an internal running CRC32. Downstream consumers get clean per-frame byte beats plus an end-of-frame status (CRC good, frame error).

## Interface

**Parameters**
- `PREAMBLE_MIN`, default 7: minimum count of consecutive 0x55 bytes accepted before the SFD.
- `MIN_FRAME`, default 64: minimum frame length in bytes, counted from the first post-SFD byte through the FCS inclusive.
- `MAX_FRAME`, default 1518: maximum frame length in bytes, same counting.

**Ports** (clock and reset: one clock; reset is asynchronous and active-high)
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: asynchronous, active-high reset.
- `rx_dv` input, 1: receive envelope. High for preamble, SFD and frame bytes; low between frames.
- `rx_er` input, 1: receive error, sampled only while `rx_dv` is high.
- `rx_data` input, 8: received byte, valid when `rx_dv` is high.
- `m_valid` output, 1: output beat valid, one cycle per beat.
- `m_data` output, 8: output byte.
- `m_sof` output, 1: first beat of frame.
- `m_eof` output, 1: last beat of frame.
- `m_crc_ok` output, 1: FCS residue correct. Meaningful only with `m_eof`.
- `m_err` output, 1: frame error. Meaningful only with `m_eof`.

## Operation

- No backpressure; every accepted input byte is consumed in its cycle.
- **States**
  - IDLE: wait for `rx_dv` high.
  - PRE: count consecutive 0x55 bytes.
  - DATA: frame body.
  - DROP: wait for `rx_dv` low.
- **IDLE**
  - `rx_dv` high with 0x55 → PRE, count=1.
  - `rx_dv` high with any other byte → DROP.
- **PRE**
  - 0x55 → count+1, saturating at 15.
  - 0xD5 with count≥`PREAMBLE_MIN` → DATA. CRC register is set to 0xFFFFFFFF and the length counter to 0.
  - Any other byte, or 0xD5 with too short a preamble → DROP.
  - `rx_dv` low → IDLE.
  - `rx_er` high → DROP.
- **DATA**
  - Each byte updates the CRC: reflected polynomial 0xEDB88320, LSB first, no output inversion.
  - Each byte increments the 11-bit length counter.
  - Each byte is pushed into the delay buffer.
  - Bytes after the counter reaches `MAX_FRAME` are discarded (no CRC update, no push) and latch a sticky error.
  - `rx_er` high latches a sticky error.
  - `rx_dv` low ends the frame → IDLE.
- **DROP**: `rx_dv` low → IDLE. Nothing is emitted.
- **Delay buffer**
  - Depth D: 5 with stripping enabled, 1 without (see Configuration).
  - A push into a full buffer emits the oldest byte.
  - `m_sof` is set on the first emitted beat of the frame.
- **End of frame** (DATA with `rx_dv` low)
  - If the buffer holds D bytes: emit the oldest byte with `m_eof`=1 and flush the rest.
  - If it holds fewer (frame shorter than D bytes): emit one beat with `m_data`=0x00, `m_sof`=1, `m_eof`=1, `m_err`=1.
- **Status on the eof beat**
  - `m_crc_ok` = (final CRC register == 0xDEBB20E3).
  - `m_err` = sticky error OR length<`MIN_FRAME` OR length≥`MAX_FRAME` with discards.
- **Reset mid-frame**: state → IDLE, buffer emptied, sticky flags cleared. The partial frame is lost with no eof beat.

## Timing

- All outputs are registered. Reset value of every output is 0.
- `m_valid`, `m_sof`, `m_eof`, `m_crc_ok` and `m_err` are single-cycle pulses.
- Frame byte n (n=0 is the first post-SFD byte) appears on `m_data` in the cycle after the edge that samples byte n+D.
- The eof beat appears in the cycle after the edge that samples `rx_dv`=0.
- Back-to-back frames separated by a single low cycle of `rx_dv` are supported. The eof beat of frame k never coincides with any beat of frame k+1, because frame k+1 needs ≥8 preamble/SFD cycles.
- `m_sof` and `m_eof` are both 1 only in the short-frame case.

## Configuration

- `ETH_RX_FCS_STRIP_EN` defined: D=5. The 4 FCS bytes are withheld and never emitted; the eof beat is the last payload byte.
- `ETH_RX_FCS_STRIP_EN` undefined: D=1. All bytes, including the FCS, are emitted; the eof beat is the final FCS byte.
- CRC checking, length checks and all status behaviour are identical in both builds.

## Test plan

- **Good frame (strip build)**
  - Stimulus: 7×0x55, 0xD5, 60 bytes 0x00..0x3B, then the bench-model FCS (LSB byte first), then `rx_dv` low.
  - Response: 60 beats of 0x00..0x3B; `m_sof` on 0x00; `m_eof` on 0x3B with `m_crc_ok`=1, `m_err`=0.
  - First beat appears the cycle after the edge sampling payload byte 5.
- **Corrupted payload**: same frame with byte 10 XOR 0x01 → same beat count, `m_crc_ok`=0 on eof.
- **Bad preamble and recovery**
  - Stimulus: 7×0x55, then 0x54, rest of frame; 1 idle cycle; then a good frame.
  - Response: no beats for the first frame; the second frame is received exactly as in the good-frame case.
- **Runts**
  - 3-byte frame after SFD → one beat: `m_data`=0x00, `m_sof`=`m_eof`=`m_err`=1.
  - 40-byte frame with valid FCS → 36 beats; eof with `m_crc_ok`=1, `m_err`=1.
- **rx_er / oversize**
  - `rx_er` pulsed on byte 20 of the good frame → eof `m_err`=1.
  - 1600-byte frame → eof `m_err`=1; beat count is `MAX_FRAME`−4.
- **Reset and no-strip build**
  - Assert `rst` at byte 30 → all outputs 0 immediately, no eof; the following good frame is received correctly.
  - Same good frame in the no-strip build → 64 beats; eof on the last FCS byte.
